// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 fetch stage: instruction width,
// bubble encoding, next-PC select encoding and the instruction ROM image.
package fetch_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam logic [INSTR_W-1:0] BUBBLE  = 32'h0000_0000;

    localparam int unsigned IMEM_INIT_AW    = 6;
    localparam int unsigned IMEM_INIT_WORDS = 1 << IMEM_INIT_AW;

    // Words 0..3: ldur, stur, add, cbz; everything else decodes as a bubble.
    localparam logic [INSTR_W-1:0] IMEM_INIT [IMEM_INIT_WORDS] = '{
        0:       32'hF840_03E9,
        1:       32'hF800_03E9,
        2:       32'h8B0A_0129,
        3:       32'hB400_0040,
        default: 32'h0000_0000
    };

    typedef enum logic [1:0] {
        PC_SEL_RESET  = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_HOLD   = 2'd2,
        PC_SEL_SEQ    = 2'd3
    } pc_sel_e;

    function automatic logic [INSTR_W-1:0] imem_init_word(input int unsigned idx);
        logic [INSTR_W-1:0] word;
        word = BUBBLE;
        if (idx < IMEM_INIT_WORDS) begin
            word = IMEM_INIT[idx[IMEM_INIT_AW-1:0]];
        end
        return word;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage control/result bundle. With FETCH_PERF_EN defined it also
// carries the fetch/stall performance counters.
interface fetch_stage_if #(
    parameter int unsigned N = 64
);
    logic           Stall;
    logic           PCSrc;
    logic [N-1:0]   PCBranch;
    logic [31:0]    instr_D;
    logic [N-1:0]   pc_D;
    logic           valid_D;
    logic [N-1:0]   pc_F;
`ifdef FETCH_PERF_EN
    logic [31:0]    fetch_count;
    logic [31:0]    stall_count;

    modport master (
        output Stall, PCSrc, PCBranch,
        input  instr_D, pc_D, valid_D, pc_F, fetch_count, stall_count
    );
    modport slave (
        input  Stall, PCSrc, PCBranch,
        output instr_D, pc_D, valid_D, pc_F, fetch_count, stall_count
    );
`else
    modport master (
        output Stall, PCSrc, PCBranch,
        input  instr_D, pc_D, valid_D, pc_F
    );
    modport slave (
        input  Stall, PCSrc, PCBranch,
        output instr_D, pc_D, valid_D, pc_F
    );
`endif
endinterface

// File: rtl/fetch_stage_imem.sv
// Read-only instruction memory with combinational read, contents taken
// from fetch_pkg::IMEM_INIT (words beyond the image read as zero).
module imem
    import fetch_pkg::*;
#(
    parameter int unsigned WORDS = 64
) (
    input  logic [$clog2(WORDS)-1:0] i_addr,
    output logic [INSTR_W-1:0]       o_data
);

    logic [INSTR_W-1:0] w_rom [WORDS];

    for (genvar g = 0; g < WORDS; g++) begin : g_rom
        assign w_rom[g] = imem_init_word(g);
    end

    assign o_data = w_rom[i_addr];

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// Optional FETCH_PERF_EN adds fetch/stall counters on the interface.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned   N          = 64,
    parameter int unsigned   IMEM_WORDS = 64,
    parameter logic [N-1:0]  RESET_PC   = '0
) (
    input  logic        clk,
    input  logic        reset,
    fetch_stage_if.slave fs
);

    localparam int unsigned  AW      = $clog2(IMEM_WORDS);
    localparam logic [N-1:0] PC_STEP = N'(4);

    logic [N-1:0]       r_pc_f;
    logic [N-1:0]       r_pc_d;
    logic [INSTR_W-1:0] r_instr_d;
    logic               r_valid_d;

    pc_sel_e            w_sel;
    logic [N-1:0]       w_pc_next;
    logic [AW-1:0]      w_imem_addr;
    logic [INSTR_W-1:0] w_imem_word;

    // Byte address to word index; upper bits dropped so fetch wraps in the ROM.
    assign w_imem_addr = r_pc_f[AW+1:2];

    imem #(
        .WORDS (IMEM_WORDS)
    ) u_imem (
        .i_addr (w_imem_addr),
        .o_data (w_imem_word)
    );

    always_comb begin
        w_sel = PC_SEL_SEQ;
        if (reset) begin
            w_sel = PC_SEL_RESET;
        end else if (fs.PCSrc) begin
            w_sel = PC_SEL_BRANCH;
        end else if (fs.Stall) begin
            w_sel = PC_SEL_HOLD;
        end
    end

    always_comb begin
        w_pc_next = r_pc_f + PC_STEP;
        case (w_sel)
            PC_SEL_RESET:  w_pc_next = RESET_PC;
            PC_SEL_BRANCH: w_pc_next = fs.PCBranch;
            PC_SEL_HOLD:   w_pc_next = r_pc_f;
            default:       w_pc_next = r_pc_f + PC_STEP;
        endcase
    end

    always_ff @(posedge clk) begin
        r_pc_f <= w_pc_next;
    end

    // Reset and redirect both leave a bubble in IF/ID.
    always_ff @(posedge clk) begin
        case (w_sel)
            PC_SEL_RESET, PC_SEL_BRANCH: begin
                r_instr_d <= BUBBLE;
                r_pc_d    <= '0;
                r_valid_d <= 1'b0;
            end
            PC_SEL_HOLD: begin
                r_instr_d <= r_instr_d;
                r_pc_d    <= r_pc_d;
                r_valid_d <= r_valid_d;
            end
            default: begin
                r_instr_d <= w_imem_word;
                r_pc_d    <= r_pc_f;
                r_valid_d <= 1'b1;
            end
        endcase
    end

    assign fs.instr_D = r_instr_d;
    assign fs.pc_D    = r_pc_d;
    assign fs.valid_D = r_valid_d;
    assign fs.pc_F    = r_pc_f;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (w_sel == PC_SEL_RESET) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_sel == PC_SEL_SEQ) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_sel == PC_SEL_HOLD) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fs.fetch_count = r_fetch_count;
    assign fs.stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the counter section runs
// only when FETCH_PERF_EN is defined.
module tb_fetch_stage;

    logic clk;
    logic reset;
    int unsigned n_tests;
    int unsigned n_fail;

    fetch_stage_if #(.N(64)) u_if ();

    fetch_stage #(
        .N          (64),
        .IMEM_WORDS (64),
        .RESET_PC   (64'h0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .fs    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [31:0] instr,
                           input logic [63:0] pc_d, input logic valid,
                           input logic [63:0] pc_f);
        check({tag, ".instr_D"}, 64'(u_if.instr_D), 64'(instr));
        check({tag, ".pc_D"},    u_if.pc_D, pc_d);
        check({tag, ".valid_D"}, 64'(u_if.valid_D), 64'(valid));
        check({tag, ".pc_F"},    u_if.pc_F, pc_f);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        u_if.Stall     = 1'b0;
        u_if.PCSrc     = 1'b0;
        u_if.PCBranch  = 64'h0;

        step();
        step();
        check_d("reset", 32'h0, 64'h0, 1'b0, 64'h0);

        reset = 1'b0;
        step();
        check_d("seq1", 32'hF84003E9, 64'h0, 1'b1, 64'h4);
        step();
        check_d("seq2", 32'hF80003E9, 64'h4, 1'b1, 64'h8);

        u_if.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_d($sformatf("stall%0d", i), 32'hF80003E9, 64'h4, 1'b1, 64'h8);
        end
        u_if.Stall = 1'b0;
        step();
        check_d("post_stall", 32'h8B0A0129, 64'h8, 1'b1, 64'hC);

        u_if.PCSrc    = 1'b1;
        u_if.PCBranch = 64'h0;
        step();
        check_d("br0_bubble", 32'h0, 64'h0, 1'b0, 64'h0);
        u_if.PCSrc = 1'b0;
        step();
        check_d("br0_target", 32'hF84003E9, 64'h0, 1'b1, 64'h4);

        u_if.PCSrc    = 1'b1;
        u_if.Stall    = 1'b1;
        u_if.PCBranch = 64'h8;
        step();
        check_d("br_stall_bubble", 32'h0, 64'h0, 1'b0, 64'h8);
        u_if.PCSrc = 1'b0;
        u_if.Stall = 1'b0;
        step();
        check_d("br_stall_target", 32'h8B0A0129, 64'h8, 1'b1, 64'hC);

        u_if.PCSrc    = 1'b1;
        u_if.PCBranch = 64'd252;
        step();
        check_d("br252_bubble", 32'h0, 64'h0, 1'b0, 64'd252);
        u_if.PCSrc = 1'b0;
        step();
        check_d("br252_target", 32'h0, 64'd252, 1'b1, 64'd256);
        step();
        check_d("seq_wrap256", 32'hF84003E9, 64'd256, 1'b1, 64'd260);

        u_if.PCSrc    = 1'b1;
        u_if.PCBranch = 64'd256;
        step();
        check_d("br256_bubble", 32'h0, 64'h0, 1'b0, 64'd256);
        u_if.PCSrc = 1'b0;
        step();
        check_d("br256_target", 32'hF84003E9, 64'd256, 1'b1, 64'd260);

        // Misaligned target: low two bits ignored, byte 10 reads word 2.
        u_if.PCSrc    = 1'b1;
        u_if.PCBranch = 64'd10;
        step();
        u_if.PCSrc = 1'b0;
        step();
        check_d("br10_target", 32'h8B0A0129, 64'd10, 1'b1, 64'd14);

        u_if.PCSrc    = 1'b1;
        u_if.PCBranch = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        u_if.PCSrc = 1'b0;
        step();
        check_d("pc_top", 32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h0);
        step();
        check_d("pc_wrap", 32'hF84003E9, 64'h0, 1'b1, 64'h4);

        reset         = 1'b1;
        u_if.Stall    = 1'b1;
        u_if.PCSrc    = 1'b1;
        u_if.PCBranch = 64'h8;
        step();
        check_d("mid_reset", 32'h0, 64'h0, 1'b0, 64'h0);
        reset      = 1'b0;
        u_if.Stall = 1'b0;
        u_if.PCSrc = 1'b0;
        step();
        check_d("after_mid_reset", 32'hF84003E9, 64'h0, 1'b1, 64'h4);

`ifdef FETCH_PERF_EN
        reset = 1'b1;
        step();
        check("perf_rst_fetch", 64'(u_if.fetch_count), 64'd0);
        check("perf_rst_stall", 64'(u_if.stall_count), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        u_if.Stall = 1'b1;
        step();
        step();
        u_if.Stall    = 1'b0;
        u_if.PCSrc    = 1'b1;
        u_if.PCBranch = 64'h0;
        step();
        u_if.PCSrc = 1'b0;
        check("perf_fetch", 64'(u_if.fetch_count), 64'd5);
        check("perf_stall", 64'(u_if.stall_count), 64'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("perf_clr_fetch", 64'(u_if.fetch_count), 64'd0);
        check("perf_clr_stall", 64'(u_if.stall_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the LEGv8 processor. It sits directly upstream of the main decoder: it holds the program counter, reads the instruction ROM and registers the fetched word into the IF/ID pipeline register, whose bits [31:21] drive the decoder's `Op` input. It supports stall (hold) and branch redirect with flush, so the decode stage sees either a valid instruction or an all-zero bubble.

## Interface
Parameters:
- `N`, 64: PC and branch-target width.
- `IMEM_WORDS`, 64: instruction ROM depth in 32-bit words; power of two.
- `RESET_PC`, 64'h0: PC value loaded on reset.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `Stall` input 1: hold PC and IF/ID contents this cycle.
- `PCSrc` input 1: branch taken; redirect fetch to `PCBranch`.
- `PCBranch` input N: branch target, byte address.
- `instr_D` output 32: IF/ID instruction; `instr_D[31:21]` feeds the decoder `Op`.
- `pc_D` output N: PC of `instr_D`.
- `valid_D` output 1: `instr_D` is a real instruction, not a bubble.
- `pc_F` output N: current fetch PC, for debug.

## Operation
- Fetch PC register `pc_F`. The ROM read is combinational: `imem_word = IMEM[pc_F[log2(IMEM_WORDS)+1:2]]`. `pc_F[1:0]` is ignored. Upper bits are truncated, so addresses wrap modulo `IMEM_WORDS*4`.
- Next-PC selection, highest priority first:
  - `reset`: PC = `RESET_PC`.
  - `PCSrc`: PC = `PCBranch`.
  - `Stall`: PC holds.
  - Otherwise: PC = `pc_F + 4`, N-bit wrap-around with no carry out.
- IF/ID register, same priority order:
  - `reset`: `instr_D` = 0, `pc_D` = 0, `valid_D` = 0.
  - `PCSrc`: flush to a bubble (`instr_D` = 32'h0, `valid_D` = 0, `pc_D` = 0).
  - `Stall`: hold all three outputs.
  - Otherwise: `instr_D` = `imem_word`, `pc_D` = `pc_F`, `valid_D` = 1.
- `PCSrc` together with `Stall`: the redirect wins. PC takes `PCBranch` and IF/ID is flushed.
- Bubble encoding 32'h0 gives opcode 11'h000, for which the decoder drives all controls low. No write side effects.
- No state machine beyond the PC register and the IF/ID register. The ROM is read-only.

## Timing
- Reset values: `pc_F` = `RESET_PC`, `pc_D` = 0, `instr_D` = 0, `valid_D` = 0.
- Latency: the word at address A, fetched while `pc_F` = A, appears on `instr_D` one rising edge later, with `pc_D` = A.
- Throughput: one instruction per cycle when `Stall` = 0.
- Branch penalty: the redirect edge produces one bubble on `instr_D`. The target instruction appears on `instr_D` at the following edge.
- Stall asserted for k cycles: `instr_D`, `pc_D` and `pc_F` stay frozen for k edges.
- `reset` asserted mid-stream takes effect at the next edge, regardless of `Stall`/`PCSrc`.
- `Stall` and `PCSrc` are sampled only at the rising edge. Combinational glitches are irrelevant.

## Configuration
- Macro `FETCH_PERF_EN`.
- Defined:
  - Adds output ports `fetch_count` [31:0] and `stall_count` [31:0].
  - `fetch_count` increments on each edge that loads `valid_D` = 1.
  - `stall_count` increments on each edge with `Stall` = 1 and `PCSrc` = 0.
  - Both counters clear on `reset` and wrap at 2^32.
- Undefined: ports and counters absent. Fetch behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - `INSTR_W` = 32.
  - `BUBBLE` = 32'h0000_0000.
  - ROM init array `IMEM_INIT`. Words 0..3: 32'hF84003E9 (ldur), 32'hF80003E9 (stur), 32'h8B0A0129 (add), 32'hB4000040 (cbz); remaining words 0.
- One sub-module `imem`: parameterised ROM, combinational read, initialised from `IMEM_INIT`.
- PC register, next-PC mux and IF/ID register stay in `fetch_stage`.

## Test plan
1. Reset held for 2 cycles, then released, no stall/branch:
   - During reset: `pc_F` = 0, `valid_D` = 0, `instr_D` = 0.
   - Edge 1 after release: `instr_D` = F84003E9, `pc_D` = 0, `pc_F` = 4.
   - Edge 2: `instr_D` = F80003E9, `pc_D` = 4.
2. `Stall` = 1 for 3 cycles while `instr_D` = F80003E9: outputs and `pc_F` = 8 are frozen for 3 edges. After release, `instr_D` = 8B0A0129 with `pc_D` = 8.
3. `PCSrc` = 1, `PCBranch` = 0 while `pc_F` = 12:
   - Next edge: `instr_D` = 0, `valid_D` = 0, `pc_F` = 0.
   - Following edge: `instr_D` = F84003E9, `pc_D` = 0.
4. `PCSrc` = 1 and `Stall` = 1 in the same cycle, `PCBranch` = 8: redirect wins. `pc_F` = 8, bubble on `instr_D`, then 8B0A0129.
5. Wrap-around with `IMEM_WORDS` = 64:
   - `PCBranch` = 252: after the bubble, `instr_D` = 0 with `pc_D` = 252.
   - `PCBranch` = 256: `instr_D` = F84003E9 (index wraps to 0).
6. With `FETCH_PERF_EN`: 5 fetches, 2 stall cycles, 1 branch, then `reset`. Before reset `fetch_count` = 5 and `stall_count` = 2; both read 0 after the reset edge.
